// File: rtl/oam_dma_pkg.sv
// rtl/oam_dma_pkg.sv - shared states and constants for the sprite DMA engine
package oam_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } state_e;

  localparam logic [15:0] OAM_DMA_ADDR   = 16'h4014;
  localparam logic [2:0]  RI_SEL_OAMDATA = 3'h4;
  localparam int          OAM_DMA_LEN    = 256;
  localparam logic [7:0]  LAST_INDEX     = 8'(OAM_DMA_LEN - 1);

endpackage

// File: rtl/oam_dma_ri_wr_strobe.sv
// rtl/oam_dma_ri_wr_strobe.sv - one-CPU-cycle write strobe toward the PPU register interface
module ri_wr_strobe
  import oam_dma_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ce_in,
  input  logic       req_in,
  input  logic [7:0] data_in,
  output logic       ncs_out,
  output logic       r_nw_out,
  output logic [2:0] sel_out,
  output logic [7:0] d_out
);

  logic       ncs_q, ncs_d;
  logic       r_nw_q, r_nw_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] d_q, d_d;

  // Each CPU cycle either carries one write or idles with ncs high; a request
  // arriving while ncs is already low is held off so the PPU always sees a fresh edge.
  always_comb begin
    ncs_d  = ncs_q;
    r_nw_d = r_nw_q;
    sel_d  = sel_q;
    d_d    = d_q;
    if (ce_in) begin
      if (req_in && ncs_q) begin
        ncs_d  = 1'b0;
        r_nw_d = 1'b0;
        sel_d  = RI_SEL_OAMDATA;
        d_d    = data_in;
      end else begin
        ncs_d  = 1'b1;
        r_nw_d = 1'b1;
      end
    end
  end

  // Strobe registers; reset forces the bus released immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ncs_q  <= 1'b1;
      r_nw_q <= 1'b1;
      sel_q  <= 3'h0;
      d_q    <= 8'h00;
    end else begin
      ncs_q  <= ncs_d;
      r_nw_q <= r_nw_d;
      sel_q  <= sel_d;
      d_q    <= d_d;
    end
  end

  assign ncs_out  = ncs_q;
  assign r_nw_out = r_nw_q;
  assign sel_out  = sel_q;
  assign d_out    = d_q;

endmodule

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA engine for 0x4014; OAM_DMA_ALIGN_EN adds odd-cycle alignment
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cpu_ce_in,
  input  logic [15:0] cpu_a_in,
  input  logic [7:0]  cpu_d_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  mem_d_in,
  output logic        cpu_rdy_out,
  output logic [15:0] mem_a_out,
  output logic        mem_rd_out,
  output logic        ri_ncs_out,
  output logic        ri_r_nw_out,
  output logic [2:0]  ri_sel_out,
  output logic [7:0]  ri_d_out,
  output logic        active_out
);

  state_e      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic        rdy_q, rdy_d;
  logic        active_q, active_d;
  logic        mem_rd_q, mem_rd_d;
  logic [15:0] mem_a_q, mem_a_d;
  logic        wr_req;
  logic        trigger;

  assign trigger = ~cpu_r_nw_in && (cpu_a_in == OAM_DMA_ADDR);

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q, parity_d;

  // Parity tracks CPU cycle odd/even from reset.
  always_comb begin
    parity_d = parity_q;
    if (cpu_ce_in) parity_d = ~parity_q;
  end

  // Parity register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end
`endif

  // Next state and registered outputs; outputs are computed from the state being
  // entered so they hold steady for the whole CPU cycle that follows.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    index_d  = index_q;
    rdy_d    = rdy_q;
    active_d = active_q;
    mem_rd_d = mem_rd_q;
    mem_a_d  = mem_a_q;
    wr_req   = 1'b0;
    if (cpu_ce_in) begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d  = ST_HALT;
            page_d   = cpu_d_in;
            index_d  = 8'h00;
            rdy_d    = 1'b0;
            active_d = 1'b1;
          end
        end
        ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          if (parity_q) begin
            state_d = ST_ALIGN;
          end else begin
            state_d  = ST_READ;
            mem_rd_d = 1'b1;
            mem_a_d  = {page_q, index_q};
          end
`else
          state_d  = ST_READ;
          mem_rd_d = 1'b1;
          mem_a_d  = {page_q, index_q};
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        ST_ALIGN: begin
          state_d  = ST_READ;
          mem_rd_d = 1'b1;
          mem_a_d  = {page_q, index_q};
        end
`endif
        ST_READ: begin
          state_d  = ST_WRITE;
          mem_rd_d = 1'b0;
          wr_req   = 1'b1;
        end
        ST_WRITE: begin
          if (index_q == LAST_INDEX) begin
            state_d  = ST_IDLE;
            rdy_d    = 1'b1;
            active_d = 1'b0;
          end else begin
            index_d  = index_q + 8'd1;
            state_d  = ST_READ;
            mem_rd_d = 1'b1;
            mem_a_d  = {page_q, index_q + 8'd1};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Engine state and bus-side output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_a_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      index_q  <= index_d;
      rdy_q    <= rdy_d;
      active_q <= active_d;
      mem_rd_q <= mem_rd_d;
      mem_a_q  <= mem_a_d;
    end
  end

  // The strobe's data register doubles as the byte latch between READ and WRITE.
  ri_wr_strobe u_strobe (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .ce_in   (cpu_ce_in),
    .req_in  (wr_req),
    .data_in (mem_d_in),
    .ncs_out (ri_ncs_out),
    .r_nw_out(ri_r_nw_out),
    .sel_out (ri_sel_out),
    .d_out   (ri_d_out)
  );

  assign cpu_rdy_out = rdy_q;
  assign active_out  = active_q;
  assign mem_rd_out  = mem_rd_q;
  assign mem_a_out   = mem_a_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - directed self-checking bench for oam_dma
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_ce = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic        cpu_rnw = 1'b1;
  logic [7:0]  mem_d;
  logic        cpu_rdy_out;
  logic [15:0] mem_a_out;
  logic        mem_rd_out;
  logic        ri_ncs_out;
  logic        ri_r_nw_out;
  logic [2:0]  ri_sel_out;
  logic [7:0]  ri_d_out;
  logic        active_out;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  exp_page = 8'h00;
  int          edge_cnt = 0, rd_cnt = 0, halt_cnt = 0, lat_cnt = 0;
  int          bad_data = 0, bad_addr = 0, ce_cnt = 0, trig_par = 0;
  logic [15:0] last_a = 16'h0000;
  logic        prev_ncs = 1'b1, prev_rd = 1'b0, prev_active = 1'b0;
  int          align;

  always #10 clk = ~clk;

  // Memory model: byte at any address is its low address byte XOR 0xA5.
  assign mem_d = mem_a_out[7:0] ^ 8'hA5;

  oam_dma dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .cpu_ce_in  (cpu_ce),
    .cpu_a_in   (cpu_a),
    .cpu_d_in   (cpu_d),
    .cpu_r_nw_in(cpu_rnw),
    .mem_d_in   (mem_d),
    .cpu_rdy_out(cpu_rdy_out),
    .mem_a_out  (mem_a_out),
    .mem_rd_out (mem_rd_out),
    .ri_ncs_out (ri_ncs_out),
    .ri_r_nw_out(ri_r_nw_out),
    .ri_sel_out (ri_sel_out),
    .ri_d_out   (ri_d_out),
    .active_out (active_out)
  );

  // Observer on the falling edge: counts ncs edges, reads and halted cycles.
  always @(negedge clk) begin
    if (rst) begin
      edge_cnt = 0; rd_cnt = 0; halt_cnt = 0; lat_cnt = 0;
      bad_data = 0; bad_addr = 0; ce_cnt = 0;
      prev_ncs = 1'b1; prev_rd = 1'b0; prev_active = 1'b0;
    end else begin
      if (active_out && !prev_active) begin
        edge_cnt = 0; rd_cnt = 0; halt_cnt = 0; lat_cnt = 0;
        bad_data = 0; bad_addr = 0;
      end
      if (prev_ncs && !ri_ncs_out) begin
        if (ri_sel_out !== 3'h4 || ri_r_nw_out !== 1'b0 || ri_d_out !== (edge_cnt[7:0] ^ 8'hA5))
          bad_data++;
        edge_cnt++;
      end
      if (mem_rd_out && !prev_rd) begin
        if (mem_a_out !== {exp_page, rd_cnt[7:0]}) bad_addr++;
        last_a = mem_a_out;
        rd_cnt++;
      end
      if (cpu_ce) begin
        if (!cpu_rdy_out) halt_cnt++;
        if (active_out && rd_cnt == 0 && !mem_rd_out) lat_cnt++;
        if (!active_out && !cpu_rnw && cpu_a == 16'h4014) trig_par = ce_cnt % 2;
        ce_cnt++;
      end
      prev_ncs    = ri_ncs_out;
      prev_rd     = mem_rd_out;
      prev_active = active_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU cycle: three clocks, cpu_ce high in the last. Entered and left at posedge+1.
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    cpu_a = a; cpu_d = d; cpu_rnw = rnw; cpu_ce = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpu_ce = 1'b1;
    @(posedge clk); #1;
    cpu_ce = 1'b0;
  endtask

  task automatic run_burst(input logic [7:0] page, input bit inject, input int stop_at);
    int n;
    exp_page = page;
    cpu_cycle(16'h4014, page, 1'b0);
    n = 0;
    while (active_out && n < 700 && edge_cnt < stop_at) begin
      if (inject && n == 100) cpu_cycle(16'h4014, 8'h07, 1'b0);
      else                    cpu_cycle(16'h0000, 8'h00, 1'b1);
      n++;
    end
  endtask

  function automatic logic [31:0] reset_vec();
    return {cpu_rdy_out, active_out, mem_rd_out, mem_a_out, ri_ncs_out, ri_r_nw_out, ri_sel_out, ri_d_out};
  endfunction

  function automatic int align_for(input int par);
`ifdef OAM_DMA_ALIGN_EN
    return (par == 0) ? 1 : 0;
`else
    return 0 * par;
`endif
  endfunction

  localparam logic [31:0] RESET_EXP = {1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'h0, 8'h00};

  initial begin
    @(posedge clk); #1;
    chk("reset_outputs", reset_vec(), RESET_EXP);
    rst = 1'b0;
    @(posedge clk); #1;

    cpu_cycle(16'h4014, 8'h02, 1'b1);
    chk("read4014_rdy", {31'd0, cpu_rdy_out}, 32'd1);
    chk("read4014_active", {31'd0, active_out}, 32'd0);
    cpu_cycle(16'h4015, 8'h02, 1'b0);
    chk("write4015_rdy", {31'd0, cpu_rdy_out}, 32'd1);
    chk("write4015_active", {31'd0, active_out}, 32'd0);

    // Page 0x02 with an ignored 0x07 trigger injected mid-burst.
    run_burst(8'h02, 1'b1, 1000);
    align = align_for(trig_par);
    chk("p02_done", {31'd0, active_out}, 32'd0);
    chk("p02_rdy", {31'd0, cpu_rdy_out}, 32'd1);
    chk("p02_ncs_idle", {31'd0, ri_ncs_out}, 32'd1);
    chk("p02_edges", edge_cnt, 256);
    chk("p02_reads", rd_cnt, 256);
    chk("p02_bad_data", bad_data, 0);
    chk("p02_bad_addr", bad_addr, 0);
    chk("p02_last_a", {16'd0, last_a}, 32'h02FF);
    chk("p02_halt", halt_cnt, 513 + align);
    chk("p02_first_rd", lat_cnt, 1 + align);

    // Page 0xFF: address stays in page 0xFF through 0xFFFF.
    run_burst(8'hFF, 1'b0, 1000);
    align = align_for(trig_par);
    chk("pff_done", {31'd0, active_out}, 32'd0);
    chk("pff_edges", edge_cnt, 256);
    chk("pff_bad_addr", bad_addr, 0);
    chk("pff_bad_data", bad_data, 0);
    chk("pff_last_a", {16'd0, last_a}, 32'hFFFF);
    chk("pff_halt", halt_cnt, 513 + align);

    // Asynchronous reset around byte 100 of a page 0x03 burst.
    run_burst(8'h03, 1'b0, 100);
    chk("p03_mid_active", {31'd0, active_out}, 32'd1);
    #5 rst = 1'b1;
    #1 chk("async_reset_outputs", reset_vec(), RESET_EXP);
    @(posedge clk); #5 rst = 1'b0;
    @(posedge clk); #1;
    cpu_cycle(16'h0000, 8'h00, 1'b1);
    chk("post_reset_rdy", {31'd0, cpu_rdy_out}, 32'd1);
    chk("post_reset_ncs", {31'd0, ri_ncs_out}, 32'd1);

    run_burst(8'h03, 1'b0, 1000);
    align = align_for(trig_par);
    chk("restart_done", {31'd0, active_out}, 32'd0);
    chk("restart_edges", edge_cnt, 256);
    chk("restart_bad_addr", bad_addr, 0);
    chk("restart_bad_data", bad_data, 0);
    chk("restart_last_a", {16'd0, last_a}, 32'h03FF);
    chk("restart_halt", halt_cnt, 513 + align);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
